// File: rtl/asrm_pkg.sv
// Shared definitions for the ASRM register bank: controller state encodings
// and the default indexes of the special-purpose registers.
package asrm_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int SR_ID_DEF = 13;
    localparam int SP_ID_DEF = 14;
    localparam int PC_ID_DEF = 15;

endpackage

// File: rtl/asrm_stack_ctl.sv
// Stack-pointer controller: next SP for a push or pop, with separate flags
// for a bounds violation and for the illegal push-and-pop combination.
module asrm_stack_ctl #(
    parameter int WORDSIZE = 16,
    parameter int SP_RESET = 4,
    parameter int SP_MAX   = 255
) (
    input  logic [WORDSIZE-1:0] sp,
    input  logic                push,
    input  logic                pop,
    output logic [WORDSIZE-1:0] sp_next,
    output logic                bound_fault,
    output logic                illegal_op
);

    localparam logic [WORDSIZE-1:0] FLOOR   = WORDSIZE'(SP_RESET);
    localparam logic [WORDSIZE-1:0] CEILING = WORDSIZE'(SP_MAX);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        sp_next     = sp;
        bound_fault = 1'b0;
        illegal_op  = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (sp == CEILING) bound_fault = 1'b1;
                else               sp_next     = sp + WORDSIZE'(1);
            end
            2'b01: begin
                if (sp == FLOOR) bound_fault = 1'b1;
                else             sp_next     = sp - WORDSIZE'(1);
            end
            2'b11:   illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/asrm_regbank.sv
// Architectural register bank with PC/SP/SR special registers, a commit
// handshake that stalls on memory, and a sticky stack-fault state.
module asrm_regbank
    import asrm_pkg::*;
#(
    parameter int WORDSIZE  = 16,
    parameter int REG_COUNT = 16,
    parameter int SR_ID     = SR_ID_DEF,
    parameter int SP_ID     = SP_ID_DEF,
    parameter int PC_ID     = PC_ID_DEF,
    parameter int SP_RESET  = 4,
    parameter int SP_MAX    = 255,
    localparam int IW       = $clog2(REG_COUNT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_valid,
    output logic                step_ready,
    input  logic                mem_busy,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic [WORDSIZE-1:0] wr_data,
    input  logic                push,
    input  logic                pop,
    input  logic [IW-1:0]       rd_a_idx,
    input  logic [IW-1:0]       rd_b_idx,
    output logic [WORDSIZE-1:0] rd_a_data,
    output logic [WORDSIZE-1:0] rd_b_data,
    output logic [WORDSIZE-1:0] pc,
    output logic [WORDSIZE-1:0] sp,
    output logic [WORDSIZE-1:0] sr,
    output logic                stack_fault,
    input  logic                fault_clr
);

    localparam logic [IW-1:0] SR_IX = IW'(SR_ID);
    localparam logic [IW-1:0] SP_IX = IW'(SP_ID);
    localparam logic [IW-1:0] PC_IX = IW'(PC_ID);

    state_t              state, state_next;
    logic [WORDSIZE-1:0] regs [REG_COUNT];
    logic [WORDSIZE-1:0] sp_next;
    logic                bound_fault, illegal_op;
    logic                commit, commit_fault, sp_write, pc_write;

    asrm_stack_ctl #(
        .WORDSIZE (WORDSIZE),
        .SP_RESET (SP_RESET),
        .SP_MAX   (SP_MAX)
    ) u_stack_ctl (
        .sp          (regs[SP_IX]),
        .push        (push),
        .pop         (pop),
        .sp_next     (sp_next),
        .bound_fault (bound_fault),
        .illegal_op  (illegal_op)
    );

    assign step_ready = (state == ST_RUN) && !mem_busy;
    assign commit     = step_valid && step_ready;
    assign sp_write   = wr_en && (wr_idx == SP_IX);
    assign pc_write   = wr_en && (wr_idx == PC_IX);
    // An explicit SP write replaces the push/pop result, so its bounds are moot.
    assign commit_fault = commit && (illegal_op || (bound_fault && !sp_write));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_RUN: begin
                if (commit_fault)  state_next = ST_FAULT;
                else if (mem_busy) state_next = ST_STALL;
            end
            ST_STALL: if (!mem_busy) state_next = ST_RUN;
            ST_FAULT: if (fault_clr) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // NOTE: the register array is reset element by element because the
    // architecture defines power-on values for every register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            regs[SR_IX] <= WORDSIZE'(1);
            regs[SP_IX] <= WORDSIZE'(SP_RESET);
            regs[PC_IX] <= '0;
        end else if (commit && !commit_fault) begin
            // NOTE: non-blocking assignments let later PC/SP lines override the
            // generic write without ordering hazards against the read ports.
            for (int i = 0; i < REG_COUNT; i++) begin
                if (wr_en && (wr_idx == IW'(i))) regs[i] <= wr_data;
            end
            if (!pc_write) regs[PC_IX] <= regs[PC_IX] + WORDSIZE'(1);
            if (!sp_write) regs[SP_IX] <= sp_next;
        end
    end

    assign rd_a_data   = regs[rd_a_idx];
    assign rd_b_data   = regs[rd_b_idx];
    assign pc          = regs[PC_IX];
    assign sp          = regs[SP_IX];
    assign sr          = regs[SR_IX];
    assign stack_fault = (state == ST_FAULT);

endmodule
